// File: rtl/uart_cmd_pkg.sv
// Shared types, ASCII constants and hex helpers for the UART register command processor.
package uart_cmd_pkg;

    // Parser / transaction states.
    typedef enum logic [2:0] {
        S_CMD     = 3'd0,
        S_SP1     = 3'd1,
        S_ADDR    = 3'd2,
        S_SP2     = 3'd3,
        S_DATA    = 3'd4,
        S_ERRSKIP = 3'd5,
        S_BUS     = 3'd6,
        S_RESP    = 3'd7
    } state_e;

    // Reply kinds loaded into the response serializer.
    typedef enum logic [1:0] {
        R_RD  = 2'd0,
        R_OK  = 2'd1,
        R_ERR = 2'd2,
        R_TMO = 2'd3
    } reply_e;

    localparam logic [7:0] LF   = 8'h0A;
    localparam logic [7:0] CR   = 8'h0D;
    localparam logic [7:0] SP   = 8'h20;
    localparam logic [7:0] CH_W = 8'h77;
    localparam logic [7:0] CH_R = 8'h72;

    // True for 0-9, a-f, A-F.
    function automatic logic is_hex(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) ||
               ((c >= 8'h61) && (c <= 8'h66)) ||
               ((c >= 8'h41) && (c <= 8'h46));
    endfunction

    // Nibble value of a character already known to be hex; letters share the low-nibble trick.
    function automatic logic [3:0] hex2nib(input logic [7:0] c);
        logic [3:0] n;
        if (c <= 8'h39) begin
            n = c[3:0];
        end else begin
            n = c[3:0] + 4'd9;
        end
        return n;
    endfunction

    // Lowercase ASCII hex digit of a nibble.
    function automatic logic [7:0] nib2hex(input logic [3:0] n);
        logic [7:0] c;
        if (n < 4'd10) begin
            c = {4'h3, n};
        end else begin
            c = 8'h57 + {4'h0, n};
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_reg_cmd_if.sv
// Generic register bus between the command processor (master) and the register file (slave).
interface uart_reg_cmd_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/uart_resp_ser.sv
// Reply byte queue: loaded in one cycle, drained one byte per tx handshake.
// Entry 0 is always the byte on offer, so tx_data comes straight from a flop.
module uart_resp_ser #(
    parameter int DEPTH = 7,
    parameter int LEN_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [LEN_W-1:0]      len,
    input  logic [DEPTH-1:0][7:0] bytes,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  done
);
    logic [DEPTH-1:0][7:0] que_q, que_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic                  hs_s;

    assign hs_s     = valid_q && tx_ready;
    assign done     = hs_s && (cnt_q == LEN_W'(1));
    assign tx_data  = que_q[0];
    assign tx_valid = valid_q;

    // Next queue contents: load replaces everything, a handshake shifts the next byte into slot 0.
    always_comb begin
        que_d   = que_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load) begin
            que_d   = bytes;
            cnt_d   = len;
            valid_d = (len != '0);
        end else if (hs_s) begin
            que_d   = que_q >> 8;
            cnt_d   = cnt_q - LEN_W'(1);
            valid_d = (cnt_q != LEN_W'(1));
        end else begin
            valid_d = valid_q;
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            que_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            que_q   <= que_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: rtl/uart_reg_cmd.sv
// Streaming ASCII command processor: "w <addr> <data>\n" / "r <addr>\n" -> one bus
// transaction -> ASCII reply. Optional macro UART_CMD_WR_ACK_EN makes writes answer "OK\n".
module uart_reg_cmd
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_vld,
    input  logic [7:0]        rx_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    uart_reg_cmd_if.master    bus,
    output logic              busy,
    output logic              rx_drop
);
    localparam int ADDR_HEX = ADDR_W / 4;
    localparam int DATA_HEX = DATA_W / 4;
    localparam int MAX_HEX  = (ADDR_HEX > DATA_HEX) ? ADDR_HEX : DATA_HEX;
    localparam int CNT_W    = $clog2(MAX_HEX + 1);
    localparam int Q_DEPTH  = (DATA_HEX + 1 > 7) ? DATA_HEX + 1 : 7;
    localparam int LEN_W    = $clog2(Q_DEPTH + 1);

    localparam logic [CNT_W-1:0] ADDR_HEX_C = CNT_W'(ADDR_HEX);
    localparam logic [CNT_W-1:0] DATA_HEX_C = CNT_W'(DATA_HEX);
    localparam logic [15:0]      TMO_LAST   = 16'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_q, req_d;
    logic [15:0]         tmo_q, tmo_d;

    logic                  byte_s;
    logic                  err_s;
    logic                  load_s;
    reply_e                reply_s;
    logic [Q_DEPTH-1:0][7:0] q_bytes_s;
    logic [LEN_W-1:0]      q_len_s;
    logic                  ser_done_s;

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = data_q;
    assign busy          = (state_q != S_CMD);
    assign rx_drop       = rx_vld && ((state_q == S_BUS) || (state_q == S_RESP));

    // Parser, bus handshake and timeout: next state and datapath updates.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        tmo_d   = tmo_q;
        err_s   = 1'b0;
        load_s  = 1'b0;
        reply_s = R_ERR;
        // CR is transparent to every parse state.
        byte_s  = rx_vld && (rx_data != CR);

        case (state_q)
            S_CMD: begin
                if (byte_s) begin
                    if (rx_data == CH_W) begin
                        we_d    = 1'b1;
                        state_d = S_SP1;
                    end else if (rx_data == CH_R) begin
                        we_d    = 1'b0;
                        state_d = S_SP1;
                    end else if (rx_data == LF) begin
                        state_d = S_CMD;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_d = S_CMD;
                end
            end
            S_SP1: begin
                if (byte_s) begin
                    if (rx_data == SP) begin
                        addr_d  = '0;
                        cnt_d   = '0;
                        state_d = S_ADDR;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_d = S_SP1;
                end
            end
            S_ADDR: begin
                if (byte_s) begin
                    if (is_hex(rx_data) && (cnt_q != ADDR_HEX_C)) begin
                        addr_d = (addr_q << 4) | ADDR_W'(hex2nib(rx_data));
                        cnt_d  = cnt_q + CNT_W'(1);
                    end else if ((rx_data == SP) && we_q && (cnt_q != '0)) begin
                        state_d = S_SP2;
                    end else if ((rx_data == LF) && !we_q && (cnt_q != '0)) begin
                        state_d = S_BUS;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_SP2: begin
                // Separator already consumed; the data field must start right here.
                if (byte_s) begin
                    if (is_hex(rx_data)) begin
                        data_d  = DATA_W'(hex2nib(rx_data));
                        cnt_d   = CNT_W'(1);
                        state_d = S_DATA;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_d = S_SP2;
                end
            end
            S_DATA: begin
                if (byte_s) begin
                    if (is_hex(rx_data) && (cnt_q != DATA_HEX_C)) begin
                        data_d = (data_q << 4) | DATA_W'(hex2nib(rx_data));
                        cnt_d  = cnt_q + CNT_W'(1);
                    end else if ((rx_data == LF) && (cnt_q != '0)) begin
                        state_d = S_BUS;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_ERRSKIP: begin
                if (byte_s && (rx_data == LF)) begin
                    load_s  = 1'b1;
                    reply_s = R_ERR;
                    state_d = S_RESP;
                end else begin
                    state_d = S_ERRSKIP;
                end
            end
            S_BUS: begin
                if (!req_q) begin
                    req_d = 1'b1;
                    tmo_d = '0;
                end else if (bus.bus_ack) begin
                    req_d = 1'b0;
                    if (we_q) begin
`ifdef UART_CMD_WR_ACK_EN
                        load_s  = 1'b1;
                        reply_s = R_OK;
                        state_d = S_RESP;
`else
                        state_d = S_CMD;
`endif
                    end else begin
                        load_s  = 1'b1;
                        reply_s = R_RD;
                        state_d = S_RESP;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    req_d   = 1'b0;
                    load_s  = 1'b1;
                    reply_s = R_TMO;
                    state_d = S_RESP;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_RESP: begin
                if (ser_done_s) begin
                    state_d = S_CMD;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_CMD;
            end
        endcase

        if (err_s) begin
            state_d = S_ERRSKIP;
        end else begin
            err_s = 1'b0;
        end
    end

    // Reply byte image for the serializer; read data is taken from the ack cycle.
    always_comb begin
        q_bytes_s = '0;
        q_len_s   = '0;
        case (reply_s)
            R_RD: begin
                for (int i = 0; i < DATA_HEX; i++) begin
                    q_bytes_s[i] = nib2hex(bus.bus_rdata[DATA_W-1-4*i -: 4]);
                end
                q_bytes_s[DATA_HEX] = LF;
                q_len_s             = LEN_W'(DATA_HEX + 1);
            end
            R_OK: begin
                q_bytes_s[0] = 8'h4F;
                q_bytes_s[1] = 8'h4B;
                q_bytes_s[2] = LF;
                q_len_s      = LEN_W'(3);
            end
            R_TMO: begin
                q_bytes_s[0] = 8'h54;
                q_bytes_s[1] = 8'h4D;
                q_bytes_s[2] = 8'h4F;
                q_bytes_s[3] = 8'h21;
                q_bytes_s[4] = LF;
                q_len_s      = LEN_W'(5);
            end
            default: begin
                q_bytes_s[0] = 8'h45;
                q_bytes_s[1] = 8'h52;
                q_bytes_s[2] = 8'h52;
                q_bytes_s[3] = 8'h4F;
                q_bytes_s[4] = 8'h52;
                q_bytes_s[5] = 8'h21;
                q_bytes_s[6] = LF;
                q_len_s      = LEN_W'(7);
            end
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_CMD;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            tmo_q   <= tmo_d;
        end
    end

    uart_resp_ser #(
        .DEPTH (Q_DEPTH),
        .LEN_W (LEN_W)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .len      (q_len_s),
        .bytes    (q_bytes_s),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (ser_done_s)
    );
endmodule

// File: tb/tb_uart_reg_cmd.sv
// Self-checking bench for uart_reg_cmd (ADDR_W=16, DATA_W=32, TIMEOUT=8).
module tb_uart_reg_cmd;
    logic        clk = 1'b0;
    logic        rst;
    logic        rx_vld;
    logic [7:0]  rx_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        rx_drop;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] txq[$];
    int rd_idx  = 0;
    int req_cnt = 0;

    uart_reg_cmd_if #(.ADDR_W(16), .DATA_W(32)) bus_if();

    uart_reg_cmd #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_vld   (rx_vld),
        .rx_data  (rx_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .bus      (bus_if.master),
        .busy     (busy),
        .rx_drop  (rx_drop)
    );

    always #5 clk = ~clk;

    // Passive monitor: every accepted tx byte and every cycle with bus_req high.
    always @(posedge clk) begin
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        if (bus_if.bus_req) req_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one rx byte for one cycle; report whether it was dropped.
    task automatic send_byte(input logic [7:0] c, output logic dropped);
        rx_vld = 1'b1;
        rx_data = c;
        #1 dropped = rx_drop;
        @(posedge clk); #1;
        rx_vld = 1'b0;
    endtask

    task automatic send_str(input string s);
        logic d;
        for (int i = 0; i < s.len(); i++) send_byte(s[i], d);
    endtask

    // Model of the bus slave: wait for a request, check it, ack after dly cycles.
    task automatic bus_xact(input string tag, input logic we, input logic [15:0] addr,
                            input logic [31:0] wd, input int dly, input logic [31:0] rd,
                            input logic rx_col);
        int n = 0;
        while (!bus_if.bus_req && n < 50) begin @(posedge clk); #1; n++; end
        chk({tag, "_req"}, bus_if.bus_req, 1'b1);
        chk({tag, "_we"}, bus_if.bus_we, we);
        chk({tag, "_addr"}, bus_if.bus_addr, addr);
        if (we) chk({tag, "_wdata"}, bus_if.bus_wdata, wd);
        chk({tag, "_busy"}, busy, 1'b1);
        repeat (dly) begin @(posedge clk); #1; end
        bus_if.bus_ack = 1'b1;
        bus_if.bus_rdata = rd;
        rx_vld = rx_col;
        rx_data = 8'h72;
        #1 if (rx_col) chk({tag, "_colldrop"}, rx_drop, 1'b1);
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0;
        bus_if.bus_rdata = $urandom;
        rx_vld = 1'b0;
        chk({tag, "_reqfall"}, bus_if.bus_req, 1'b0);
    endtask

    // Wait for the processor to go idle, then compare collected tx bytes with exp.
    task automatic expect_reply(input string tag, input string exp);
        int n = 0;
        while (busy && n < 400) begin @(posedge clk); #1; n++; end
        chk({tag, "_idle"}, busy, 1'b0);
        chk({tag, "_len"}, txq.size() - rd_idx, exp.len());
        for (int i = 0; i < exp.len() && rd_idx + i < txq.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), txq[rd_idx + i], exp[i]);
        rd_idx = txq.size();
    endtask

    function automatic string hexch(input int v, input bit upper);
        int c;
        if (v < 10) c = 48 + v;
        else c = (upper ? 55 : 87) + v;
        return $sformatf("%c", c);
    endfunction

    function automatic string hexfield(input logic [31:0] val, input int nd);
        string s = "";
        for (int i = nd - 1; i >= 0; i--) s = {s, hexch(int'((val >> (4 * i)) & 32'hF), bit'($urandom_range(0, 1)))};
        return s;
    endfunction

    initial begin
        logic        d;
        logic [7:0]  held;
        int          bad, n, base, an, dn, dly;
        logic        we;
        logic [15:0] a;
        logic [31:0] wd, rd;
        string       cmd, wr_exp;

`ifdef UART_CMD_WR_ACK_EN
        wr_exp = "OK\n";
`else
        wr_exp = "";
`endif
        rst = 1'b1;
        rx_vld = 1'b0;
        rx_data = 8'h00;
        tx_ready = 1'b1;
        bus_if.bus_ack = 1'b0;
        bus_if.bus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_txv", tx_valid, 1'b0);
        chk("rst_txd", tx_data, 8'h00);
        chk("rst_req", bus_if.bus_req, 1'b0);
        chk("rst_we", bus_if.bus_we, 1'b0);
        chk("rst_addr", bus_if.bus_addr, 16'h0);
        chk("rst_wdata", bus_if.bus_wdata, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop", rx_drop, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic read with ack after 3 cycles.
        send_str("r 10\n");
        bus_xact("rd10", 1'b0, 16'h0010, 32'h0, 3, 32'h000000A5, 1'b0);
        expect_reply("rd10", "000000a5\n");

        // Write with CR before LF, short fields zero-extended.
        send_str("w 1 3\r\n");
        bus_xact("wr13", 1'b1, 16'h0001, 32'h00000003, 1, 32'h0, 1'b0);
        expect_reply("wr13", wr_exp);

        // Parse errors: bad digit, address overflow, bad command. No bus request.
        base = req_cnt;
        send_str("r 123g\n");
        expect_reply("err_g", "ERROR!\n");
        send_str("r 12345\n");
        expect_reply("err_ovf", "ERROR!\n");
        send_str("x\n");
        expect_reply("err_cmd", "ERROR!\n");
        send_str("\n");
        chk("lf_idle", busy, 1'b0);
        chk("err_noreq", req_cnt - base, 0);

        // Timeout: request held for exactly TIMEOUT cycles.
        send_str("r 00\n");
        n = 0;
        while (!bus_if.bus_req && n < 50) begin @(posedge clk); #1; n++; end
        n = 0;
        while (bus_if.bus_req && n < 50) begin @(posedge clk); #1; n++; end
        chk("tmo_cycles", n, 8);
        expect_reply("tmo", "TMO!\n");

        // Back-pressure mid-reply with rx traffic during the reply.
        send_str("r 5\n");
        bus_xact("stall", 1'b0, 16'h0005, 32'h0, 0, 32'hDEADBEEF, 1'b0);
        n = 0;
        while (txq.size() - rd_idx < 2 && n < 50) begin @(posedge clk); #1; n++; end
        tx_ready = 1'b0;
        held = tx_data;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i < 3) begin
                rx_vld = 1'b1;
                rx_data = 8'h77;
                #1 chk($sformatf("stall_drop%0d", i), rx_drop, 1'b1);
            end
            @(posedge clk); #1;
            rx_vld = 1'b0;
            if (tx_data !== held || tx_valid !== 1'b1) bad++;
        end
        chk("stall_stable", bad, 0);
        chk("stall_held", tx_data, 8'h61);
        tx_ready = 1'b1;
        expect_reply("stall", "deadbeef\n");

        // Asynchronous reset during the bus phase aborts without a reply.
        send_str("r 00\n");
        n = 0;
        while (!bus_if.bus_req && n < 50) begin @(posedge clk); #1; n++; end
        chk("mrst_req_before", bus_if.bus_req, 1'b1);
        rst = 1'b1;
        #1;
        chk("mrst_req", bus_if.bus_req, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_txv", tx_valid, 1'b0);
        chk("mrst_addr", bus_if.bus_addr, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("mrst_noreply", txq.size() - rd_idx, 0);
        send_str("r 00\n");
        bus_xact("post_rst", 1'b0, 16'h0000, 32'h0, 2, 32'h0123ABCD, 1'b0);
        expect_reply("post_rst", "0123abcd\n");

        // Randomized commands against the field-level model.
        for (int it = 0; it < 12; it++) begin
            we  = bit'($urandom_range(0, 1));
            an  = $urandom_range(1, 4);
            dn  = $urandom_range(1, 8);
            a   = 16'($urandom & ((32'd1 << (4 * an)) - 32'd1));
            wd  = (dn == 8) ? $urandom : ($urandom & ((32'd1 << (4 * dn)) - 32'd1));
            rd  = $urandom;
            dly = $urandom_range(0, 6);
            cmd = {we ? "w " : "r ", hexfield({16'h0, a}, an)};
            if (we) cmd = {cmd, " ", hexfield(wd, dn)};
            if ($urandom_range(0, 1) == 1) cmd = {cmd, "\r"};
            cmd = {cmd, "\n"};
            send_str(cmd);
            bus_xact($sformatf("rnd%0d", it), we, a, wd, dly, rd, bit'(it == 3));
            expect_reply($sformatf("rnd%0d", it), we ? wr_exp : $sformatf("%08h\n", rd));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
